// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: operation encodings, EX/MEM and
// MEM/WB bundle field offsets, FSM states and the MEM/WB packing helper.
package memory_stage_pkg;

  localparam int WORD_W = 16;
  localparam int EXM_W  = 76;
  localparam int MW_W   = 38;

  // MEM op encodings (2'b11 behaves as no access)
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;
  localparam logic [1:0] MEM_RSVD  = 2'b11;

  // SP op encodings (2'b11 behaves as no stack operation)
  localparam logic [1:0] SP_NONE = 2'b00;
  localparam logic [1:0] SP_PUSH = 2'b01;
  localparam logic [1:0] SP_POP  = 2'b10;

  // EX/MEM field offsets
  localparam int EXM_RSRC_LSB  = 28;
  localparam int EXM_ALU_LSB   = 12;
  localparam int EXM_RDST_LSB  = 6;
  localparam int EXM_MEMOP_LSB = 4;
  localparam int EXM_SPOP_LSB  = 2;
  localparam int EXM_WB_BIT    = 1;
  localparam int EXM_LDD_BIT   = 0;

  // MEM/WB field offsets
  localparam int MW_VALID_BIT = 37;
  localparam int MW_RDATA_LSB = 21;
  localparam int MW_ALU_LSB   = 5;
  localparam int MW_RDST_LSB  = 2;
  localparam int MW_WB_BIT    = 1;
  localparam int MW_LDD_BIT   = 0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  // Fields of an accepted memory instruction kept for its completion
  typedef struct packed {
    logic [WORD_W-1:0] alu;
    logic [2:0]        rdst;
    logic [1:0]        sp_op;
    logic              wb;
    logic              ldd;
  } work_t;

  function automatic logic [MW_W-1:0] pack_mw(
    input logic              valid,
    input logic [WORD_W-1:0] rdata,
    input logic [WORD_W-1:0] alu,
    input logic [2:0]        rdst,
    input logic              wb,
    input logic              ldd
  );
    logic [MW_W-1:0] r;
    r                          = '0;
    r[MW_VALID_BIT]            = valid;
    r[MW_RDATA_LSB +: WORD_W]  = rdata;
    r[MW_ALU_LSB +: WORD_W]    = alu;
    r[MW_RDST_LSB +: 3]        = rdst;
    r[MW_WB_BIT]               = wb;
    r[MW_LDD_BIT]              = ldd;
    return r;
  endfunction

endpackage

// File: rtl/mem_sp_unit.sv
// Stack-pointer unit: holds SP, selects the access address for push/pop
// (push uses SP, pop uses SP+1, anything else uses the ALU result) and
// applies the SP update when a stack transaction commits.
module mem_sp_unit
  import memory_stage_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] SP_RESET = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        addr_sp_op,
  input  logic [ADDR_W-1:0] alu_addr,
  output logic [ADDR_W-1:0] addr,
  input  logic              commit,
  input  logic [1:0]        commit_sp_op,
  output logic [ADDR_W-1:0] sp
);

  // Address select for the instruction being accepted; wraps modulo 2^ADDR_W
  always_comb begin
    addr = alu_addr;
    case (addr_sp_op)
      SP_NONE: addr = alu_addr;
      SP_PUSH: addr = sp;
      SP_POP:  addr = sp + ADDR_W'(1);
      default: addr = alu_addr;
    endcase
  end

  // SP moves only when a stack transaction completes
  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= SP_RESET;
    end else if (commit) begin
      if (commit_sp_op == SP_PUSH) begin
        sp <= sp - ADDR_W'(1);
      end else if (commit_sp_op == SP_POP) begin
        sp <= sp + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: passes non-memory instructions to MEM/WB with one
// cycle of latency, and runs one req/ready data-memory transaction per
// load/store/push/pop while stalling upstream. A transaction that waits
// WAIT_LIMIT cycles is aborted and flagged with a sticky mem_err.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] SP_RESET   = 16'hFFFF,
  parameter int                WAIT_LIMIT = 255
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [EXM_W-1:0]  In,
  input  logic              In_valid,
  output logic              Stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [MW_W-1:0]   Out,
  output logic              mem_err
);

  localparam int               CNT_W    = $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  logic [WORD_W-1:0] in_rsrc;
  logic [WORD_W-1:0] in_alu;
  logic [2:0]        in_rdst;
  logic [1:0]        in_mem_op;
  logic [1:0]        in_sp_op;
  logic              in_wb;
  logic              in_ldd;
  logic              in_is_mem;
  logic              unused_in;

  state_t            state;
  work_t             ex_p1;
  logic [CNT_W-1:0]  wait_cnt;
  logic [MW_W-1:0]   mw_p2;
  logic [ADDR_W-1:0] acc_addr;
  logic [ADDR_W-1:0] sp;
  logic              commit;

  assign in_rsrc   = In[EXM_RSRC_LSB +: WORD_W];
  assign in_alu    = In[EXM_ALU_LSB +: WORD_W];
  assign in_rdst   = In[EXM_RDST_LSB +: 3];
  assign in_mem_op = In[EXM_MEMOP_LSB +: 2];
  assign in_sp_op  = In[EXM_SPOP_LSB +: 2];
  assign in_wb     = In[EXM_WB_BIT];
  assign in_ldd    = In[EXM_LDD_BIT];
  // Upper bundle bits and the Rsrc register address are not needed here
  assign unused_in = ^{In[EXM_W-1:EXM_RSRC_LSB+WORD_W], In[EXM_RDST_LSB+5:EXM_RDST_LSB+3]};

  assign in_is_mem = In_valid && !(in_mem_op == MEM_NONE || in_mem_op == MEM_RSVD);
  assign commit    = (state == ST_ACCESS) && mem_ready;
  assign Out       = mw_p2;

  mem_sp_unit #(
    .ADDR_W   (ADDR_W),
    .SP_RESET (SP_RESET)
  ) u_sp (
    .clk          (CLK),
    .rst          (Reset),
    .addr_sp_op   (in_sp_op),
    .alu_addr     (ADDR_W'(in_alu)),
    .addr         (acc_addr),
    .commit       (commit),
    .commit_sp_op (ex_p1.sp_op),
    .sp           (sp)
  );

  // Stage FSM: accept in IDLE, hold the request stable through ACCESS, retire to MEM/WB
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= ST_IDLE;
      Stall    <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_err  <= 1'b0;
      wait_cnt <= '0;
      mw_p2    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_is_mem) begin
            state         <= ST_ACCESS;
            Stall         <= 1'b1;
            mem_req       <= 1'b1;
            mem_we        <= (in_mem_op == MEM_WRITE);
            mem_addr      <= acc_addr;
            mem_wdata     <= in_rsrc;
            ex_p1.alu     <= in_alu;
            ex_p1.rdst    <= in_rdst;
            ex_p1.sp_op   <= in_sp_op;
            ex_p1.wb      <= in_wb;
            ex_p1.ldd     <= in_ldd;
            wait_cnt      <= '0;
            mw_p2         <= '0;
          end else begin
            mw_p2 <= pack_mw(In_valid, '0, in_alu, in_rdst, in_wb, in_ldd);
          end
        end
        ST_ACCESS: begin
          if (mem_ready) begin
            state   <= ST_IDLE;
            Stall   <= 1'b0;
            mem_req <= 1'b0;
            mw_p2   <= pack_mw(1'b1, mem_we ? '0 : mem_rdata, ex_p1.alu,
                               ex_p1.rdst, ex_p1.wb, ex_p1.ldd);
          end else if (wait_cnt == CNT_LAST) begin
            // Timed out: retire as a harmless bubble-with-valid and flag the error
            state   <= ST_IDLE;
            Stall   <= 1'b0;
            mem_req <= 1'b0;
            mem_err <= 1'b1;
            mw_p2   <= pack_mw(1'b1, '0, ex_p1.alu, ex_p1.rdst, 1'b0, ex_p1.ldd);
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            mw_p2    <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: a table of single-cycle pass-through
// vectors followed by hand-written memory transaction sequences.
module tb_memory_stage;

  localparam int WAIT_LIMIT = 255;

  logic        clk;
  logic        reset;
  logic [75:0] in_bus;
  logic        in_valid;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [37:0] out_bus;
  logic        mem_err;

  int n_cmp  = 0;
  int n_fail = 0;

  memory_stage #(
    .ADDR_W     (16),
    .SP_RESET   (16'hFFFF),
    .WAIT_LIMIT (WAIT_LIMIT)
  ) dut (
    .CLK       (clk),
    .Reset     (reset),
    .In        (in_bus),
    .In_valid  (in_valid),
    .Stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .Out       (out_bus),
    .mem_err   (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [75:0] in;
    logic        vld;
    logic [37:0] exp_out;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [75:0] mk(input logic [15:0] rsrc, input logic [15:0] alu,
                                     input logic [2:0] rdst, input logic [1:0] mop,
                                     input logic [1:0] sop, input logic wb, input logic ldd);
    // Ignored bits carry junk so that leaking them into Out is visible
    return {32'hDEADBEEF, rsrc, alu, 3'b101, rdst, mop, sop, wb, ldd};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One memory instruction: accept, watch ACCESS, complete; ready_at=0 means never ready
  task automatic do_mem(input string name, input logic [75:0] ins, input int ready_at,
                        input logic [15:0] rdata, input logic exp_we,
                        input logic [15:0] exp_addr, input logic [15:0] exp_wdata,
                        input int exp_cycles, input logic [37:0] exp_out,
                        input logic [15:0] exp_sp);
    int cycles;
    in_bus    = ins;
    in_valid  = 1'b1;
    mem_ready = 1'b0;
    tick();
    in_valid  = 1'b0;
    cycles    = 0;
    while (stall === 1'b1 && cycles < WAIT_LIMIT + 10) begin
      chk({name, " req"},   64'(mem_req),   64'(1'b1));
      chk({name, " we"},    64'(mem_we),    64'(exp_we));
      chk({name, " addr"},  64'(mem_addr),  64'(exp_addr));
      chk({name, " wdata"}, 64'(mem_wdata), 64'(exp_wdata));
      chk({name, " bubble"}, 64'(out_bus[37]), 64'(1'b0));
      cycles++;
      if (cycles == ready_at) begin
        mem_ready = 1'b1;
        mem_rdata = rdata;
      end
      tick();
      mem_ready = 1'b0;
      mem_rdata = 16'h0;
    end
    chk({name, " stall cycles"}, 64'(cycles), 64'(exp_cycles));
    chk({name, " out"},      64'(out_bus),  64'(exp_out));
    chk({name, " stall off"}, 64'(stall),   64'(1'b0));
    chk({name, " req off"},  64'(mem_req),  64'(1'b0));
    chk({name, " sp"},       64'(dut.sp),   64'(exp_sp));
  endtask

  initial begin
    reset     = 1'b1;
    in_bus    = '0;
    in_valid  = 1'b0;
    mem_rdata = 16'h0;
    mem_ready = 1'b0;
    tick();
    tick();
    chk("reset out",   64'(out_bus), 64'(0));
    chk("reset stall", 64'(stall),   64'(0));
    chk("reset req",   64'(mem_req), 64'(0));
    chk("reset err",   64'(mem_err), 64'(0));
    chk("reset sp",    64'(dut.sp),  64'(16'hFFFF));
    reset = 1'b0;

    // Pass-through vectors: {valid, rdata=0, alu, rdst, wb, ldd} one cycle later
    vecs[0] = '{"alu op", mk(16'h0000, 16'h1234, 3'd5, 2'b00, 2'b00, 1'b1, 1'b0), 1'b1,
                {1'b1, 16'h0000, 16'h1234, 3'd5, 1'b1, 1'b0}};
    vecs[1] = '{"memop11 push", mk(16'h1111, 16'hABCD, 3'd2, 2'b11, 2'b01, 1'b0, 1'b1), 1'b1,
                {1'b1, 16'h0000, 16'hABCD, 3'd2, 1'b0, 1'b1}};
    vecs[2] = '{"invalid read", mk(16'h2222, 16'h5555, 3'd7, 2'b01, 2'b00, 1'b1, 1'b1), 1'b0,
                {1'b0, 16'h0000, 16'h5555, 3'd7, 1'b1, 1'b1}};
    vecs[3] = '{"pop no mem", mk(16'h3333, 16'h0F0F, 3'd0, 2'b00, 2'b10, 1'b1, 1'b0), 1'b1,
                {1'b1, 16'h0000, 16'h0F0F, 3'd0, 1'b1, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      in_bus   = vecs[i].in;
      in_valid = vecs[i].vld;
      tick();
      chk({vecs[i].name, " out"},   64'(out_bus), 64'(vecs[i].exp_out));
      chk({vecs[i].name, " stall"}, 64'(stall),   64'(0));
      chk({vecs[i].name, " req"},   64'(mem_req), 64'(0));
    end
    in_valid = 1'b0;
    tick();
    chk("sp after no-mem ops", 64'(dut.sp), 64'(16'hFFFF));

    // Load with ready in the third ACCESS cycle
    do_mem("load", mk(16'h0000, 16'h0040, 3'd3, 2'b01, 2'b00, 1'b1, 1'b1), 3, 16'hBEEF,
           1'b0, 16'h0040, 16'h0000, 3, {1'b1, 16'hBEEF, 16'h0040, 3'd3, 1'b1, 1'b1}, 16'hFFFF);
    // Push from reset SP, then pop straight back (back-to-back acceptance)
    do_mem("push", mk(16'h00AA, 16'h0000, 3'd0, 2'b10, 2'b01, 1'b0, 1'b0), 1, 16'hFFFF,
           1'b1, 16'hFFFF, 16'h00AA, 1, {1'b1, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0}, 16'hFFFE);
    do_mem("pop", mk(16'h0000, 16'h0099, 3'd4, 2'b01, 2'b10, 1'b1, 1'b0), 2, 16'h1357,
           1'b0, 16'hFFFF, 16'h0000, 2, {1'b1, 16'h1357, 16'h0099, 3'd4, 1'b1, 1'b0}, 16'hFFFF);
    // Wrap-around in both directions
    do_mem("pop wrap", mk(16'h0000, 16'h0001, 3'd1, 2'b01, 2'b10, 1'b1, 1'b0), 1, 16'h2468,
           1'b0, 16'h0000, 16'h0000, 1, {1'b1, 16'h2468, 16'h0001, 3'd1, 1'b1, 1'b0}, 16'h0000);
    chk("err after pop wrap", 64'(mem_err), 64'(0));
    do_mem("push wrap", mk(16'h7777, 16'h0002, 3'd2, 2'b10, 2'b01, 1'b0, 1'b0), 2, 16'hAAAA,
           1'b1, 16'h0000, 16'h7777, 2, {1'b1, 16'h0000, 16'h0002, 3'd2, 1'b0, 1'b0}, 16'hFFFF);

    // Timeout: never ready, abort after WAIT_LIMIT cycles with wb forced low
    do_mem("abort", mk(16'h0000, 16'h0100, 3'd6, 2'b01, 2'b00, 1'b1, 1'b1), 0, 16'h0000,
           1'b0, 16'h0100, 16'h0000, WAIT_LIMIT,
           {1'b1, 16'h0000, 16'h0100, 3'd6, 1'b0, 1'b1}, 16'hFFFF);
    chk("err after abort", 64'(mem_err), 64'(1));
    in_bus   = mk(16'h0000, 16'h4321, 3'd3, 2'b00, 2'b00, 1'b1, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("err sticky", 64'(mem_err), 64'(1));
    chk("alu after abort", 64'(out_bus), 64'({1'b1, 16'h0000, 16'h4321, 3'd3, 1'b1, 1'b0}));

    // Reset in the middle of a push, coinciding with mem_ready: no SP update
    in_bus   = mk(16'h00CC, 16'h0000, 3'd0, 2'b10, 2'b01, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid-access req", 64'(mem_req), 64'(1));
    reset     = 1'b1;
    mem_ready = 1'b1;
    tick();
    reset     = 1'b0;
    mem_ready = 1'b0;
    chk("rst mid req",   64'(mem_req), 64'(0));
    chk("rst mid out",   64'(out_bus), 64'(0));
    chk("rst mid stall", 64'(stall),   64'(0));
    chk("rst mid sp",    64'(dut.sp),  64'(16'hFFFF));
    chk("rst mid err",   64'(mem_err), 64'(0));
    in_bus   = mk(16'h0000, 16'h00EE, 3'd7, 2'b00, 2'b00, 1'b1, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("idle after rst", 64'(out_bus), 64'({1'b1, 16'h0000, 16'h00EE, 3'd7, 1'b1, 1'b1}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
